jelly3_uart_rx: RTL

Oversampling UART receiver for the jelly3 peripheral set: it recovers bytes from the serial line and presents them as a valid/ready stream for the RX FIFO of the UART register block. It also reports framing, parity, overrun and break conditions. Single clock domain; the serial input is asynchronous and is synchronised internally.

---
 rtl/jelly3_uart_rx.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/jelly3_uart_rx.sv
// Oversampling UART receiver: 16 ticks per bit, majority vote at ticks 7/8/9,
// valid/ready byte output with framing, parity, overrun and break reporting.
module jelly3_uart_rx #(
  parameter int unsigned DIVIDER_BITS = 8,
  parameter int unsigned SYNC_STAGES  = 2
) (
  input  logic                    aresetn,
  input  logic                    aclk,
  input  logic [DIVIDER_BITS-1:0] divider,
  input  logic                    parity_en,
  input  logic                    parity_odd,
  input  logic                    uart_rx,
  output logic [7:0]              m_data,
  output logic                    m_valid,
  input  logic                    m_ready,
  output logic                    err_framing,
  output logic                    err_parity,
  output logic                    err_overrun,
  output logic                    break_det,
  output logic                    busy
);

  typedef enum logic [2:0] {
    StIdle, StStart, StData, StParity, StStop, StWaitHigh
  } state_e;

  state_e                  state_q, state_d;
  logic [SYNC_STAGES-1:0]  sync_q, sync_d;
  logic [DIVIDER_BITS-1:0] cnt_q, cnt_d;
  logic [3:0]              sub_q, sub_d;
  logic [2:0]              bit_idx_q, bit_idx_d;
  logic [7:0]              shreg_q, shreg_d;
  logic                    par_en_q, par_en_d;
  logic                    par_odd_q, par_odd_d;
  logic                    par_bit_q, par_bit_d;
  logic                    samp7_q, samp7_d;
  logic                    samp8_q, samp8_d;
  logic [7:0]              m_data_q, m_data_d;
  logic                    m_valid_q, m_valid_d;
  logic                    err_fr_q, err_fr_d;
  logic                    err_par_q, err_par_d;
  logic                    err_ovr_q, err_ovr_d;
  logic                    brk_q, brk_d;

  logic rx_s;
  logic tick;
  logic vote;
  logic par_ok;

  assign rx_s   = sync_q[SYNC_STAGES-1];
  assign vote   = (samp7_q & samp8_q) | (samp7_q & rx_s) | (samp8_q & rx_s);
  // Total ones (data + parity bit) is odd exactly when the reduction XOR is 1.
  assign par_ok = ((^{shreg_q, par_bit_q}) == par_odd_q);

  always_comb begin
    sync_d    = {sync_q[SYNC_STAGES-2:0], uart_rx};
    tick      = (cnt_q >= divider);
    cnt_d     = tick ? '0 : cnt_q + DIVIDER_BITS'(1);
    state_d   = state_q;
    sub_d     = sub_q;
    bit_idx_d = bit_idx_q;
    shreg_d   = shreg_q;
    par_en_d  = par_en_q;
    par_odd_d = par_odd_q;
    par_bit_d = par_bit_q;
    samp7_d   = samp7_q;
    samp8_d   = samp8_q;
    m_data_d  = m_data_q;
    m_valid_d = m_valid_q & ~m_ready;
    err_fr_d  = 1'b0;
    err_par_d = 1'b0;
    err_ovr_d = 1'b0;
    brk_d     = brk_q;

    if (tick) begin
      if (state_q inside {StStart, StData, StParity, StStop}) begin
        sub_d = sub_q + 4'd1;
        if (sub_q == 4'd7) samp7_d = rx_s;
        if (sub_q == 4'd8) samp8_d = rx_s;
      end
      unique case (state_q)
        StIdle: begin
          if (!rx_s) begin
            state_d   = StStart;
            sub_d     = 4'd0;
            par_en_d  = parity_en;
            par_odd_d = parity_odd;
            par_bit_d = 1'b0;
            shreg_d   = 8'h00;
            bit_idx_d = 3'd0;
          end
        end
        StStart: begin
          if (sub_q == 4'd9 && vote) begin
            state_d = StIdle;
            sub_d   = 4'd0;
          end else if (sub_q == 4'd15) begin
            state_d = StData;
          end
        end
        StData: begin
          if (sub_q == 4'd9) shreg_d = {vote, shreg_q[7:1]};
          if (sub_q == 4'd15) begin
            if (bit_idx_q == 3'd7) state_d = par_en_q ? StParity : StStop;
            else                   bit_idx_d = bit_idx_q + 3'd1;
          end
        end
        StParity: begin
          if (sub_q == 4'd9)  par_bit_d = vote;
          if (sub_q == 4'd15) state_d = StStop;
        end
        StStop: begin
          if (sub_q == 4'd9) begin
            sub_d = 4'd0;
            if (!vote) begin
              state_d  = StWaitHigh;
              err_fr_d = 1'b1;
              if (shreg_q == 8'h00 && (!par_en_q || !par_bit_q)) brk_d = 1'b1;
            end else begin
              state_d   = StIdle;
              err_par_d = par_en_q & ~par_ok;
              if (!m_valid_q || m_ready) begin
                m_data_d  = shreg_q;
                m_valid_d = 1'b1;
              end else begin
                err_ovr_d = 1'b1;
              end
            end
          end
        end
        StWaitHigh: begin
          if (rx_s) begin
            state_d = StIdle;
            brk_d   = 1'b0;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state_q   <= StIdle;
      sync_q    <= '1;
      cnt_q     <= '0;
      sub_q     <= 4'd0;
      bit_idx_q <= 3'd0;
      shreg_q   <= 8'h00;
      par_en_q  <= 1'b0;
      par_odd_q <= 1'b0;
      par_bit_q <= 1'b0;
      samp7_q   <= 1'b1;
      samp8_q   <= 1'b1;
      m_data_q  <= 8'h00;
      m_valid_q <= 1'b0;
      err_fr_q  <= 1'b0;
      err_par_q <= 1'b0;
      err_ovr_q <= 1'b0;
      brk_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      sync_q    <= sync_d;
      cnt_q     <= cnt_d;
      sub_q     <= sub_d;
      bit_idx_q <= bit_idx_d;
      shreg_q   <= shreg_d;
      par_en_q  <= par_en_d;
      par_odd_q <= par_odd_d;
      par_bit_q <= par_bit_d;
      samp7_q   <= samp7_d;
      samp8_q   <= samp8_d;
      m_data_q  <= m_data_d;
      m_valid_q <= m_valid_d;
      err_fr_q  <= err_fr_d;
      err_par_q <= err_par_d;
      err_ovr_q <= err_ovr_d;
      brk_q     <= brk_d;
    end
  end

  assign m_data      = m_data_q;
  assign m_valid     = m_valid_q;
  assign err_framing = err_fr_q;
  assign err_parity  = err_par_q;
  assign err_overrun = err_ovr_q;
  assign break_det   = brk_q;
  assign busy        = (state_q != StIdle);

endmodule
